// File: rtl/hwpe_ctrl_regfile_bist_ctrl.sv
// March C- BIST sequencer for the HWPE control regfile test wrapper; 1 op/cycle, read data compared 1 cycle later.
// Busy for 10N+1 cycles; start_i ignored while busy; clear aborts the test.
module hwpe_ctrl_regfile_bist_ctrl #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8,
    localparam int NUM_BYTE     = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fail_o,
    output logic [ADDR_WIDTH-1:0]    fail_addr_o,
    output logic [2:0]               fail_elem_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    output logic                     bist_o,
    output logic                     csn_o,
    output logic                     wen_o,
    output logic [ADDR_WIDTH-1:0]    a_o,
    output logic [DATA_WIDTH-1:0]    d_o,
    output logic [NUM_BYTE-1:0]      be_o,
    input  logic [DATA_WIDTH-1:0]    q_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     ph_q, ph_d;
    logic                     start_acc;

    logic                     rd_vld_q;
    logic [DATA_WIDTH-1:0]    exp_q;
    logic [ADDR_WIDTH-1:0]    rd_addr_q;
    logic [2:0]               rd_elem_q;
    logic                     mismatch;

    logic                     fail_q;
    logic [ADDR_WIDTH-1:0]    fail_addr_q;
    logic [2:0]               fail_elem_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic                     bist_q, bist_d;
    logic                     csn_q, csn_d;
    logic                     wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]    a_q, a_d;
    logic [DATA_WIDTH-1:0]    d_q, d_d;

    function automatic logic is_op(input state_e st);
        return (st inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5});
    endfunction

    // Two-op elements read in phase 0 and write in phase 1.
    function automatic logic is_rd(input state_e st, input logic ph);
        case (st)
            S_M1, S_M2, S_M3, S_M4: return !ph;
            S_M5:                   return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Data polarity of the op: expected word for reads, write word for writes.
    function automatic logic op_ones(input state_e st, input logic ph);
        case (st)
            S_M1, S_M3: return ph;
            S_M2, S_M4: return !ph;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] elem_of(input state_e st);
        case (st)
            S_M1:    return 3'd1;
            S_M2:    return 3'd2;
            S_M3:    return 3'd3;
            S_M4:    return 3'd4;
            S_M5:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    assign start_acc = start_i && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ph_d    = ph_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_acc) begin
                    state_d = S_M0;
                    addr_d  = '0;
                    ph_d    = 1'b0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_M1, S_M2: begin
                ph_d = !ph_q;
                if (ph_q) begin
                    if (addr_q == ADDR_MAX) begin
                        state_d = (state_q == S_M1) ? S_M2 : S_M3;
                        addr_d  = (state_q == S_M1) ? '0 : ADDR_MAX;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_M3, S_M4: begin
                ph_d = !ph_q;
                if (ph_q) begin
                    if (addr_q == '0) begin
                        state_d = (state_q == S_M3) ? S_M4 : S_M5;
                        addr_d  = (state_q == S_M3) ? ADDR_MAX : '0;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            S_M5: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Port registers are loaded from the next op so the op lands on the port with its state.
    always_comb begin
        bist_d = (state_d inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN});
        csn_d  = !is_op(state_d);
        wen_d  = !is_op(state_d) || is_rd(state_d, ph_d);
        a_d    = is_op(state_d) ? addr_d : '0;
        d_d    = '0;
        if (is_op(state_d) && !is_rd(state_d, ph_d)) begin
            d_d = {DATA_WIDTH{op_ones(state_d, ph_d)}};
        end
    end

    assign mismatch = rd_vld_q && (q_i != exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            rd_vld_q    <= 1'b0;
            exp_q       <= '0;
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_cnt_q   <= '0;
            bist_q      <= 1'b0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            rd_vld_q    <= 1'b0;
            exp_q       <= '0;
            rd_addr_q   <= '0;
            rd_elem_q   <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_cnt_q   <= '0;
            bist_q      <= 1'b0;
            csn_q       <= 1'b1;
            wen_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ph_q      <= ph_d;
            bist_q    <= bist_d;
            csn_q     <= csn_d;
            wen_q     <= wen_d;
            a_q       <= a_d;
            d_q       <= d_d;
            // Current op's expectation travels with it to the next cycle, when q_i is valid.
            rd_vld_q  <= is_op(state_q) && is_rd(state_q, ph_q);
            exp_q     <= {DATA_WIDTH{op_ones(state_q, ph_q)}};
            rd_addr_q <= addr_q;
            rd_elem_q <= elem_of(state_q);
            if (start_acc) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= '0;
                err_cnt_q   <= '0;
            end else if (mismatch) begin
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= rd_addr_q;
                    fail_elem_q <= rd_elem_q;
                end
            end
        end
    end

    assign busy_o      = (state_q inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN});
    assign done_o      = (state_q == S_DONE);
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign err_cnt_o   = err_cnt_q;
    assign bist_o      = bist_q;
    assign csn_o       = csn_q;
    assign wen_o       = wen_q;
    assign a_o         = a_q;
    assign d_o         = d_q;
    assign be_o        = {NUM_BYTE{1'b1}};

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist_ctrl.sv
// Directed bench: two BIST controllers, each driving a behavioural regfile with selectable faults.
module tb_hwpe_ctrl_regfile_bist_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic          busy, done, fail, bist, csn, wen;
    logic [AW-1:0] fail_addr, a;
    logic [2:0]    fail_elem;
    logic [7:0]    err_cnt;
    logic [DW-1:0] d, q;
    logic [NB-1:0] be;

    logic          clear2 = 1'b0;
    logic          start2 = 1'b0;
    logic          busy2, done2, fail2, bist2, csn2, wen2;
    logic [AW-1:0] fail_addr2, a2;
    logic [2:0]    fail_elem2;
    logic [3:0]    err_cnt2;
    logic [DW-1:0] d2, q2;
    logic [NB-1:0] be2;

    hwpe_ctrl_regfile_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start_i(start),
        .busy_o(busy), .done_o(done), .fail_o(fail), .fail_addr_o(fail_addr),
        .fail_elem_o(fail_elem), .err_cnt_o(err_cnt), .bist_o(bist), .csn_o(csn),
        .wen_o(wen), .a_o(a), .d_o(d), .be_o(be), .q_i(q)
    );

    hwpe_ctrl_regfile_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .start_i(start2),
        .busy_o(busy2), .done_o(done2), .fail_o(fail2), .fail_addr_o(fail_addr2),
        .fail_elem_o(fail_elem2), .err_cnt_o(err_cnt2), .bist_o(bist2), .csn_o(csn2),
        .wen_o(wen2), .a_o(a2), .d_o(d2), .be_o(be2), .q_i(q2)
    );

    // 0: fault-free, 1: bit 5 of addr 7 stuck-at-1, 2: write to 12 inverts addr 11
    int fault_mode = 0;
    logic [DW-1:0] mem  [N];
    logic [DW-1:0] mem2 [N];

    always @(posedge clk) begin
        if (!csn) begin
            if (!wen) begin
                mem[a] <= d;
                if (fault_mode == 2 && a == 5'd12) mem[11] <= ~mem[11];
            end else begin
                q <= (fault_mode == 1 && a == 5'd7) ? (mem[a] | 32'h20) : mem[a];
            end
        end
    end

    always @(posedge clk) begin
        if (!csn2) begin
            if (!wen2) mem2[a2] <= d2;
            else       q2 <= ~mem2[a2];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic          e_wen [10*N];
    logic [AW-1:0] e_a   [10*N];
    logic [DW-1:0] e_d   [10*N];
    int n_exp = 0;

    task automatic push(input logic w, input int ad, input logic [DW-1:0] dd);
        e_wen[n_exp] = w;
        e_a[n_exp]   = AW'(ad);
        e_d[n_exp]   = dd;
        n_exp++;
    endtask

    task automatic build_seq();
        n_exp = 0;
        for (int i = 0; i < N; i++) push(1'b0, i, '0);
        for (int i = 0; i < N; i++) begin push(1'b1, i, '0); push(1'b0, i, '1); end
        for (int i = 0; i < N; i++) begin push(1'b1, i, '0); push(1'b0, i, '0); end
        for (int i = N-1; i >= 0; i--) begin push(1'b1, i, '0); push(1'b0, i, '1); end
        for (int i = N-1; i >= 0; i--) begin push(1'b1, i, '0); push(1'b0, i, '0); end
        for (int i = 0; i < N; i++) push(1'b1, i, '0);
    endtask

    int busy_cnt, done_cnt, done_at, idx, seq_err, n_wr, n_rd, be_err;
    logic post_clr_bist, post_clr_csn, post_clr_busy, post_clr_fail, post_done_busy;
    logic [7:0] post_clr_err;

    // Cycle k = k-th sampled cycle with busy high; accounting stops once done is seen.
    task automatic run_test(input int clear_at, input int rs_a, input int rs_b, input bit start_on_done);
        logic clr_prev, done_prev, seen_done;
        busy_cnt = 0; done_cnt = 0; done_at = 0; idx = 0; seq_err = 0;
        n_wr = 0; n_rd = 0; be_err = 0; post_done_busy = 1'b0;
        clr_prev = 1'b0; done_prev = 1'b0; seen_done = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 330; k++) begin
            if (done_prev) begin post_done_busy = busy; done_prev = 1'b0; end
            if (clr_prev) begin
                post_clr_bist = bist; post_clr_csn = csn; post_clr_busy = busy;
                post_clr_fail = fail; post_clr_err = err_cnt; clr_prev = 1'b0;
            end
            if (!seen_done) begin
                if (busy) busy_cnt++;
                if (bist && be !== '1) be_err++;
                if (!csn) begin
                    if (idx >= n_exp || wen !== e_wen[idx] || a !== e_a[idx] ||
                        (!wen && d !== e_d[idx])) seq_err++;
                    if (wen) n_rd++; else n_wr++;
                    idx++;
                end
            end
            if (done) begin
                done_cnt++;
                if (!seen_done) done_at = busy_cnt;
                seen_done = 1'b1;
            end
            start = (busy && (busy_cnt == rs_a || busy_cnt == rs_b)) || (start_on_done && done);
            clear = busy && busy_cnt == clear_at && !clr_prev;
            if (clear) clr_prev = 1'b1;
            if (start_on_done && done) done_prev = 1'b1;
            @(negedge clk);
            start = 1'b0;
            clear = 1'b0;
        end
    endtask

    initial begin
        build_seq();
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_fail", 64'(fail), 64'd0);
        check_eq("rst_fail_addr", 64'(fail_addr), 64'd0);
        check_eq("rst_fail_elem", 64'(fail_elem), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("rst_bist", 64'(bist), 64'd0);
        check_eq("rst_csn", 64'(csn), 64'd1);
        check_eq("rst_wen", 64'(wen), 64'd1);
        check_eq("rst_a", 64'(a), 64'd0);
        check_eq("rst_d", 64'(d), 64'd0);
        check_eq("rst_be", 64'(be), 64'hF);
        rst_n = 1'b1;

        fault_mode = 0;
        run_test(-1, -1, -1, 0);
        check_eq("clean_busy_cycles", 64'(busy_cnt), 64'd321);
        check_eq("clean_done_pulses", 64'(done_cnt), 64'd1);
        check_eq("clean_fail", 64'(fail), 64'd0);
        check_eq("clean_err_cnt", 64'(err_cnt), 64'd0);
        check_eq("clean_seq_err", 64'(seq_err), 64'd0);
        check_eq("clean_ops", 64'(idx), 64'd320);
        check_eq("clean_writes", 64'(n_wr), 64'd160);
        check_eq("clean_reads", 64'(n_rd), 64'd160);
        check_eq("clean_be", 64'(be_err), 64'd0);

        fault_mode = 1;
        run_test(-1, -1, -1, 0);
        check_eq("saf_fail", 64'(fail), 64'd1);
        check_eq("saf_addr", 64'(fail_addr), 64'd7);
        check_eq("saf_elem", 64'(fail_elem), 64'd1);
        check_eq("saf_err_cnt", 64'(err_cnt), 64'd3);
        check_eq("saf_done", 64'(done_cnt), 64'd1);

        fault_mode = 2;
        run_test(-1, -1, -1, 0);
        check_eq("cf_fail", 64'(fail), 64'd1);
        check_eq("cf_addr", 64'(fail_addr), 64'd11);
        check_eq("cf_elem", 64'(fail_elem), 64'd1);

        // stuck-at fault makes diagnostics non-zero before the clear at cycle 100
        fault_mode = 1;
        run_test(100, -1, -1, 0);
        check_eq("clr_bist", 64'(post_clr_bist), 64'd0);
        check_eq("clr_csn", 64'(post_clr_csn), 64'd1);
        check_eq("clr_busy", 64'(post_clr_busy), 64'd0);
        check_eq("clr_fail", 64'(post_clr_fail), 64'd0);
        check_eq("clr_err_cnt", 64'(post_clr_err), 64'd0);
        check_eq("clr_no_done", 64'(done_cnt), 64'd0);
        check_eq("clr_busy_cycles", 64'(busy_cnt), 64'd100);

        fault_mode = 0;
        run_test(-1, -1, -1, 0);
        check_eq("after_clr_busy_cycles", 64'(busy_cnt), 64'd321);
        check_eq("after_clr_done", 64'(done_cnt), 64'd1);
        check_eq("after_clr_fail", 64'(fail), 64'd0);
        check_eq("after_clr_seq_err", 64'(seq_err), 64'd0);

        run_test(-1, 5, 200, 1);
        check_eq("restart_busy_cycles", 64'(busy_cnt), 64'd321);
        check_eq("restart_done", 64'(done_cnt), 64'd1);
        check_eq("restart_done_at", 64'(done_at), 64'd321);
        check_eq("restart_seq_err", 64'(seq_err), 64'd0);
        check_eq("start_on_done_busy", 64'(post_done_busy), 64'd1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_bist", 64'(bist), 64'd0);
        check_eq("arst_csn", 64'(csn), 64'd1);
        check_eq("arst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (330) @(negedge clk);
        check_eq("inv_err_cnt_sat", 64'(err_cnt2), 64'd15);
        check_eq("inv_fail", 64'(fail2), 64'd1);
        check_eq("inv_addr", 64'(fail_addr2), 64'd0);
        check_eq("inv_elem", 64'(fail_elem2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
